// File: rtl/clause_pkg.sv
// Shared clause-table constants and the loader/arbiter state encoding.
// A clause word holds NUM_LITS literals of LIT_W bits each.
package clause_pkg;

  localparam int LIT_W    = 24;
  localparam int NUM_LITS = 20;
  localparam int ADDR_W   = 11;
  localparam int DATA_W   = LIT_W * NUM_LITS;

  typedef enum logic {
    LOAD = 1'b0,
    RUN  = 1'b1
  } state_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter: combinational grant from valid and pointer;
// on contention the pointer moves to the losing requester.
module rr_arb2 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clr,
  input  logic [1:0] valid,
  output logic [1:0] grant,
  output logic       ptr
);

  logic ptr_reg;
  logic ptr_next;

  always_comb begin
    grant    = 2'b00;
    ptr_next = ptr_reg;
    unique case (valid)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      2'b11: begin
        grant    = ptr_reg ? 2'b10 : 2'b01;
        ptr_next = ~ptr_reg;
      end
      default: grant = 2'b00;
    endcase
    if (clr) begin
      ptr_next = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_reg <= 1'b0;
    end else begin
      ptr_reg <= ptr_next;
    end
  end

  assign ptr = ptr_reg;

endmodule

// File: rtl/clause_table_arb.sv
// Clause table front end: sequential loader writes clause words into an
// external memory, then two requesters share the read port round-robin.
module clause_table_arb #(
  parameter int ADDR_W = clause_pkg::ADDR_W,
  parameter int DATA_W = clause_pkg::DATA_W,
  parameter int NREQ   = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   clr,
  input  logic                   ld_valid,
  input  logic [DATA_W-1:0]      ld_data,
  input  logic                   ld_last,
  output logic                   ld_ready,
  output logic                   ld_done,
  output logic [ADDR_W:0]        num_clauses,
  input  logic [NREQ-1:0]        rq_valid,
  input  logic [NREQ*ADDR_W-1:0] rq_addr,
  output logic [NREQ-1:0]        rq_ready,
  output logic                   rsp_valid,
  output logic                   rsp_id,
  output logic                   rsp_err,
  output logic [DATA_W-1:0]      rsp_data,
  output logic                   mem_read,
  output logic                   mem_write,
  output logic [ADDR_W-1:0]      mem_addr,
  output logic [DATA_W-1:0]      mem_wdata,
  input  logic [DATA_W-1:0]      mem_q
);

  import clause_pkg::*;

  localparam logic [ADDR_W:0] MAX_CLAUSES = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W:0] LAST_SLOT   = MAX_CLAUSES - 1'b1;

  state_t          state_reg, state_next;
  logic [ADDR_W:0] num_reg, num_next;
  logic            ld_done_reg, ld_done_next;
  // Cleared by reset, set on the first clock after release; keeps every
  // handshake output low while rst_n is held without sampling rst_n as data.
  logic            live_reg;

  logic            rsp_valid_reg;
  logic            rsp_id_reg;
  logic            rsp_err_reg;

  logic            ld_fire;
  logic            last_beat;
  logic [1:0]      arb_valid;
  logic [1:0]      grant;
  logic            arb_ptr;
  logic            gnt_any;
  logic            gnt_idx;
  logic [ADDR_W-1:0] gnt_addr;
  logic            in_range;

  // Loader handshake; clr takes priority over a beat in the same cycle.
  assign ld_ready  = live_reg && (state_reg == LOAD) && !num_reg[ADDR_W] && !clr;
  assign ld_fire   = ld_valid && ld_ready;
  assign last_beat = ld_last || (num_reg == LAST_SLOT);

  assign arb_valid = rq_valid[1:0] & {2{live_reg && (state_reg == RUN) && !clr}};

  rr_arb2 u_arb (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (clr),
    .valid (arb_valid),
    .grant (grant),
    .ptr   (arb_ptr)
  );

  assign rq_ready = grant;
  assign gnt_any  = |grant;
  assign gnt_idx  = grant[1];
  assign gnt_addr = gnt_idx ? rq_addr[ADDR_W +: ADDR_W] : rq_addr[0 +: ADDR_W];
  assign in_range = ({1'b0, gnt_addr} < num_reg);

  assign mem_write = ld_fire;
  assign mem_read  = gnt_any && in_range;
  assign mem_addr  = ld_fire ? num_reg[ADDR_W-1:0] : gnt_addr;
  assign mem_wdata = ld_data;

  always_comb begin
    state_next   = state_reg;
    num_next     = num_reg;
    ld_done_next = ld_done_reg;
    if (clr) begin
      state_next   = LOAD;
      num_next     = '0;
      ld_done_next = 1'b0;
    end else begin
      unique case (state_reg)
        LOAD: begin
          if (ld_fire) begin
            num_next = num_reg + 1'b1;
            if (last_beat) begin
              state_next   = RUN;
              ld_done_next = 1'b1;
            end
          end
        end
        RUN:     state_next = RUN;
        default: state_next = LOAD;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg   <= LOAD;
      num_reg     <= '0;
      ld_done_reg <= 1'b0;
      live_reg    <= 1'b0;
    end else begin
      state_reg   <= state_next;
      num_reg     <= num_next;
      ld_done_reg <= ld_done_next;
      live_reg    <= 1'b1;
    end
  end

  // Response pipeline is not touched by clr so an in-flight read still lands.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_valid_reg <= 1'b0;
      rsp_id_reg    <= 1'b0;
      rsp_err_reg   <= 1'b0;
    end else begin
      rsp_valid_reg <= gnt_any;
      rsp_id_reg    <= gnt_any ? gnt_idx : 1'b0;
      rsp_err_reg   <= gnt_any && !in_range;
    end
  end

  assign ld_done     = ld_done_reg;
  assign num_clauses = num_reg;
  assign rsp_valid   = rsp_valid_reg;
  assign rsp_id      = rsp_id_reg;
  assign rsp_err     = rsp_err_reg;
  assign rsp_data    = rsp_err_reg ? '0 : mem_q;

endmodule

// File: tb/tb_clause_table_arb.sv
// Directed bench for clause_table_arb with a behavioural clause memory.
// Expected values are hand-derived from the stimulus vectors.
module tb_clause_table_arb;

  localparam int AW = clause_pkg::ADDR_W;
  localparam int DW = clause_pkg::DATA_W;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             clr;
  logic             ld_valid;
  logic [DW-1:0]    ld_data;
  logic             ld_last;
  logic             ld_ready;
  logic             ld_done;
  logic [AW:0]      num_clauses;
  logic [1:0]       rq_valid;
  logic [2*AW-1:0]  rq_addr;
  logic [1:0]       rq_ready;
  logic             rsp_valid;
  logic             rsp_id;
  logic             rsp_err;
  logic [DW-1:0]    rsp_data;
  logic             mem_read;
  logic             mem_write;
  logic [AW-1:0]    mem_addr;
  logic [DW-1:0]    mem_wdata;
  logic [DW-1:0]    mem_q;

  logic [DW-1:0]    mem [0:(1<<AW)-1];

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  clause_table_arb dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .clr         (clr),
    .ld_valid    (ld_valid),
    .ld_data     (ld_data),
    .ld_last     (ld_last),
    .ld_ready    (ld_ready),
    .ld_done     (ld_done),
    .num_clauses (num_clauses),
    .rq_valid    (rq_valid),
    .rq_addr     (rq_addr),
    .rq_ready    (rq_ready),
    .rsp_valid   (rsp_valid),
    .rsp_id      (rsp_id),
    .rsp_err     (rsp_err),
    .rsp_data    (rsp_data),
    .mem_read    (mem_read),
    .mem_write   (mem_write),
    .mem_addr    (mem_addr),
    .mem_wdata   (mem_wdata),
    .mem_q       (mem_q)
  );

  always @(posedge clk) begin
    if (mem_write) mem[mem_addr] <= mem_wdata;
    if (mem_read)  mem_q <= mem[mem_addr];
  end

  function automatic logic [DW-1:0] pat(input int i);
    logic [31:0] w;
    w = 32'(i) ^ 32'hA5A5_0000;
    return {15{w}};
  endfunction

  task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  initial begin
    rst_n = 1'b1; clr = 1'b0; ld_valid = 1'b0; ld_data = '0; ld_last = 1'b0;
    rq_valid = 2'b00; rq_addr = '0;
    #1 rst_n = 1'b0;
    // Reset state with requests and a beat presented
    ld_valid = 1'b1; rq_valid = 2'b11;
    #2;
    check("rst_ld_ready", ld_ready, 0);
    check("rst_rq_ready", rq_ready, 0);
    check("rst_mem_write", mem_write, 0);
    check("rst_mem_read", mem_read, 0);
    check("rst_num", num_clauses, 0);
    check("rst_ld_done", ld_done, 0);
    check("rst_rsp_valid", rsp_valid, 0);
    ld_valid = 1'b0; rq_valid = 2'b00;
    @(negedge clk) rst_n = 1'b1;
    @(negedge clk);

    // Load three clauses, last on the third
    for (int i = 0; i < 3; i++) begin
      ld_valid = 1'b1; ld_data = pat(i); ld_last = (i == 2);
      #1;
      check($sformatf("ld%0d_ready", i), ld_ready, 1);
      check($sformatf("ld%0d_write", i), mem_write, 1);
      check($sformatf("ld%0d_addr", i), mem_addr, i);
      check($sformatf("ld%0d_wdata", i), mem_wdata, pat(i));
      check($sformatf("ld%0d_num", i), num_clauses, i);
      $display("load beat %0d addr=%0d", i, mem_addr);
      @(negedge clk);
    end
    ld_valid = 1'b0; ld_last = 1'b0;
    #1;
    check("ld_num3", num_clauses, 3);
    check("ld_done", ld_done, 1);
    check("ld_ready_off", ld_ready, 0);
    check("ld_write_off", mem_write, 0);

    // Both requesters every cycle: req0 -> addr 0, req1 -> addr 2
    @(negedge clk);
    rq_addr = {11'd2, 11'd0}; rq_valid = 2'b11;
    for (int k = 0; k < 6; k++) begin
      #1;
      check($sformatf("rr%0d_grant", k), rq_ready, (k % 2) ? 2'b10 : 2'b01);
      check($sformatf("rr%0d_read", k), mem_read, 1);
      check($sformatf("rr%0d_addr", k), mem_addr, (k % 2) ? 2 : 0);
      if (k > 0) begin
        check($sformatf("rr%0d_rvalid", k), rsp_valid, 1);
        check($sformatf("rr%0d_rid", k), rsp_id, (k - 1) % 2);
        check($sformatf("rr%0d_rdata", k), rsp_data, pat(((k - 1) % 2) ? 2 : 0));
      end
      $display("rr cycle %0d grant=%b rsp_id=%0d", k, rq_ready, rsp_id);
      @(negedge clk);
    end
    rq_valid = 2'b00;
    #1;
    check("rr_tail_rvalid", rsp_valid, 1);
    check("rr_tail_rid", rsp_id, 1);
    check("rr_tail_rerr", rsp_err, 0);
    check("rr_tail_rdata", rsp_data, pat(2));
    check("rr_idle_grant", rq_ready, 0);

    // Out-of-range requests: address 5 then address 3 (== num_clauses)
    @(negedge clk);
    rq_valid = 2'b01; rq_addr = {11'd0, 11'd5};
    #1;
    check("oor5_grant", rq_ready, 2'b01);
    check("oor5_noread", mem_read, 0);
    check("oor5_prev_idle", rsp_valid, 0);
    @(negedge clk);
    rq_valid = 2'b10; rq_addr = {11'd3, 11'd0};
    #1;
    check("oor5_rvalid", rsp_valid, 1);
    check("oor5_rerr", rsp_err, 1);
    check("oor5_rid", rsp_id, 0);
    check("oor5_rdata", rsp_data, 0);
    check("oor3_grant", rq_ready, 2'b10);
    check("oor3_noread", mem_read, 0);
    @(negedge clk);
    rq_valid = 2'b00;
    #1;
    check("oor3_rvalid", rsp_valid, 1);
    check("oor3_rerr", rsp_err, 1);
    check("oor3_rid", rsp_id, 1);
    $display("out-of-range responses checked");

    // clr with a response in flight
    @(negedge clk);
    rq_valid = 2'b10; rq_addr = {11'd1, 11'd0};
    #1;
    check("clr_pre_grant", rq_ready, 2'b10);
    check("clr_pre_read", mem_read, 1);
    check("clr_pre_addr", mem_addr, 1);
    @(negedge clk);
    clr = 1'b1; rq_valid = 2'b01;
    #1;
    check("clr_nogrant", rq_ready, 0);
    check("clr_noread", mem_read, 0);
    check("clr_inflight_valid", rsp_valid, 1);
    check("clr_inflight_id", rsp_id, 1);
    check("clr_inflight_err", rsp_err, 0);
    check("clr_inflight_data", rsp_data, pat(1));
    @(negedge clk);
    clr = 1'b0; rq_valid = 2'b11;
    #1;
    check("clr_post_rvalid", rsp_valid, 0);
    check("clr_post_num", num_clauses, 0);
    check("clr_post_done", ld_done, 0);
    check("clr_post_ld_ready", ld_ready, 1);
    check("clr_post_rq_ready", rq_ready, 0);
    rq_valid = 2'b00;
    $display("clr sequence checked");

    // Asynchronous reset in the middle of a load beat
    ld_valid = 1'b1; ld_data = pat(7);
    @(negedge clk);
    ld_data = pat(8);
    #1;
    check("arst_pre_num", num_clauses, 1);
    check("arst_pre_write", mem_write, 1);
    check("arst_pre_addr", mem_addr, 1);
    #1 rst_n = 1'b0;
    #1;
    check("arst_write", mem_write, 0);
    check("arst_ld_ready", ld_ready, 0);
    check("arst_num", num_clauses, 0);
    check("arst_done", ld_done, 0);
    check("arst_rvalid", rsp_valid, 0);
    ld_valid = 1'b0;
    @(negedge clk) rst_n = 1'b1;
    @(negedge clk);
    #1;
    check("arst_post_write", mem_write, 0);
    check("arst_post_num", num_clauses, 0);
    check("arst_mem1_kept", mem[1], pat(1));
    $display("async reset during beat checked");

    // Fill the whole table without ld_last
    @(negedge clk);
    for (int i = 0; i < (1 << AW); i++) begin
      ld_valid = 1'b1; ld_data = pat(i);
      if (i == (1 << AW) - 1) begin
        #1;
        check("full_last_addr", mem_addr, (1 << AW) - 1);
        check("full_last_write", mem_write, 1);
        check("full_last_num", num_clauses, (1 << AW) - 1);
        $display("fill beat %0d addr=%0d", i + 1, mem_addr);
      end
      @(negedge clk);
    end
    ld_valid = 1'b0;
    #1;
    check("full_num", num_clauses, 1 << AW);
    check("full_done", ld_done, 1);
    check("full_ld_ready", ld_ready, 0);
    rq_valid = 2'b01; rq_addr = {11'd0, 11'd2047};
    #1;
    check("full_top_grant", rq_ready, 2'b01);
    check("full_top_read", mem_read, 1);
    check("full_top_addr", mem_addr, 2047);
    @(negedge clk);
    rq_valid = 2'b00;
    #1;
    check("full_top_rerr", rsp_err, 0);
    check("full_top_rdata", rsp_data, pat(2047));
    $display("full table read of address 2047 checked");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/clause_table_arb.md
CLAUSE_TABLE_ARB -- requirements
Module: clause_table_arb

Interface
REQ-001 SHALL have parameter ADDR_W, default 11, meaning clause address width (2048 entries).
REQ-002 SHALL have parameter DATA_W, default 480, meaning clause word width (20 literals x 24 bits).
REQ-003 SHALL have parameter NREQ, default 2, meaning number of read requesters; only 2 is supported.
REQ-004 clk  in  1  single clock; all logic on rising edge.
REQ-005 rst_n  in  1  reset; asynchronous, active-low.
REQ-006 clr  in  1  synchronous restart of clause loading.
REQ-007 ld_valid  in  1  loader beat valid.
REQ-008 ld_data  in  DATA_W  clause word to store.
REQ-009 ld_last  in  1  final clause of the formula.
REQ-010 ld_ready  out  1  loader beat accepted when ld_valid&ld_ready.
REQ-011 ld_done  out  1  load complete; table readable.
REQ-012 num_clauses  out  ADDR_W+1  clauses stored (0..2048).
REQ-013 rq_valid  in  NREQ  per-requester read request.
REQ-014 rq_addr  in  NREQ*ADDR_W  per-requester address, requester i at bits [i*ADDR_W +: ADDR_W].
REQ-015 rq_ready  out  NREQ  per-requester grant; request consumed when valid&ready.
REQ-016 rsp_valid  out  1  response valid; no backpressure.
REQ-017 rsp_id  out  1  requester index of the response.
REQ-018 rsp_err  out  1  address was >= num_clauses; data invalid.
REQ-019 rsp_data  out  DATA_W  clause word.
REQ-020 mem_read, mem_write  out  1 each  clause memory read/write enables.
REQ-021 mem_addr  out  ADDR_W  clause memory address.
REQ-022 mem_wdata  out  DATA_W  clause memory write data.
REQ-023 mem_q  in  DATA_W  clause memory read data, valid the cycle after mem_read.

Function
REQ-024 SHALL implement two states: LOAD and RUN.
REQ-025 In LOAD, ld_ready SHALL be 1 while num_clauses < 2048, and rq_ready SHALL be 0.
REQ-026 On a LOAD beat: mem_write=1, mem_addr=num_clauses[ADDR_W-1:0], mem_wdata=ld_data (same cycle), and num_clauses SHALL increment next cycle.
REQ-027 A beat with ld_last=1, or the beat making num_clauses=2048, SHALL move the state to RUN and set ld_done=1 next cycle.
REQ-028 In RUN, ld_ready=0 and mem_write=0; clr SHALL return the state to LOAD, zero num_clauses, clear ld_done and the RR pointer, and suppress any grant that cycle.
REQ-029 In RUN, at most one request SHALL be granted per cycle; rq_ready SHALL be combinational from rq_valid, state and the RR pointer.
REQ-030 Arbitration SHALL be round-robin: a lone valid requester is granted; with both valid, the requester named by the pointer wins; the pointer SHALL then point at the loser.
REQ-031 For a granted address < num_clauses: mem_read=1 and mem_addr=that address the same cycle.
REQ-032 For a granted address >= num_clauses: mem_read SHALL stay 0.
REQ-033 One cycle after a grant: rsp_valid=1, rsp_id=granted index, rsp_err=out-of-range flag, and rsp_data=mem_q (pass-through; 0 when rsp_err=1).
REQ-034 Back-to-back grants SHALL yield back-to-back responses with sustained throughput of 1 per cycle.
REQ-035 clr with a response in flight SHALL still deliver that response next cycle.
REQ-036 mem_read and mem_write SHALL never both be 1.

Reset
REQ-037 rst_n low SHALL immediately force state LOAD, num_clauses=0, ld_done=0, RR pointer=0, and rsp_valid/rsp_err/rsp_id=0.
REQ-038 While rst_n is low, ld_ready, rq_ready, mem_read and mem_write SHALL be 0.
REQ-039 An in-flight response SHALL be dropped on reset.

Structure
REQ-040 ADDR_W, DATA_W, LIT_W=24, NUM_LITS=20 and the state enum SHALL live in shared package clause_pkg.
REQ-041 The round-robin arbiter SHALL be sub-module rr_arb2 (valid in, grant out, pointer update); everything else is flat.

Verification
REQ-042 Load 3 clauses, last on the 3rd -> writes at addresses 0,1,2; num_clauses=3; ld_done=1 the next cycle; ld_ready=0 after.
REQ-043 Stream 2048 beats with no ld_last -> beat 2048 writes address 2047; state goes to RUN; ld_ready drops.
REQ-044 Both requesters valid every cycle for 6 cycles, num_clauses=3 -> grants alternate 0,1,0,1,0,1; rsp_id follows each grant by 1 cycle.
REQ-045 Request address 5 with num_clauses=3 -> no mem_read; next cycle rsp_valid=1, rsp_err=1, rsp_data=0.
REQ-046 Assert clr in the same cycle as a grant-eligible request -> no grant; the earlier in-flight response is still delivered; then LOAD with num_clauses=0.
REQ-047 Pull rst_n low during a LOAD beat -> all outputs reach reset values without a clock edge; no write occurs after release until a new beat.
